// File: rtl/prbs31_pkg.sv
// rtl/prbs31_pkg.sv - PRBS31 constants, checker state type and tap helper shared with the generator
package prbs31_pkg;

  localparam int PRBS_LEN  = 31;
  localparam int TAP_A     = 31;
  localparam int TAP_B     = 28;
  localparam int WIN_LEN   = 256;
  localparam int WIN_W     = $clog2(WIN_LEN);
  localparam int ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } prbs_state_t;

  function automatic logic prbs31_predict(input logic [PRBS_LEN-1:0] sr);
    return sr[TAP_A-1] ^ sr[TAP_B-1];
  endfunction

endpackage

// File: rtl/prbs31_lfsr_step.sv
// rtl/prbs31_lfsr_step.sv - one combinational PRBS31 step: predicted bit and advanced register
module prbs31_lfsr_step
  import prbs31_pkg::*;
(
  input  logic [PRBS_LEN-1:0] i_sr,
  output logic                o_bit,
  output logic [PRBS_LEN-1:0] o_sr_next
);

  assign o_bit     = prbs31_predict(i_sr);
  assign o_sr_next = {i_sr[PRBS_LEN-2:0], o_bit};

endmodule

// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - PRBS31 lock/error checker; PRBS31_CHK_INV_EN adds inv input for inverted streams
module prbs31_checker
  import prbs31_pkg::*;
#(
  parameter int LOCK_CNT    = 64,
  parameter int UNLOCK_ERRS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 din_vld,
  input  logic                 din,
`ifdef PRBS31_CHK_INV_EN
  input  logic                 inv,
`endif
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam int FILL_W  = $clog2(PRBS_LEN + 1);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int WERR_W  = $clog2(UNLOCK_ERRS + 1);

  prbs_state_t            r_state;
  logic [PRBS_LEN-1:0]    r_sr;
  logic [FILL_W-1:0]      r_fill;
  logic [MATCH_W-1:0]     r_match;
  logic [WIN_W-1:0]       r_win_cnt;
  logic [WERR_W-1:0]      r_win_errs;
  logic                   r_locked;
  logic                   r_err_pulse;
  logic [ERR_CNT_W-1:0]   r_err_cnt;

  prbs_state_t            w_state_nxt;
  logic [PRBS_LEN-1:0]    w_sr_nxt;
  logic [FILL_W-1:0]      w_fill_nxt;
  logic [MATCH_W-1:0]     w_match_nxt;
  logic [WIN_W-1:0]       w_win_cnt_nxt;
  logic [WERR_W-1:0]      w_win_errs_nxt;
  logic [ERR_CNT_W-1:0]   w_err_cnt_nxt;
  logic                   w_err_hit;
  logic                   w_din;
  logic                   w_pred;
  logic                   w_mismatch;
  logic [PRBS_LEN-1:0]    w_sr_pred;
  logic [PRBS_LEN-1:0]    w_sr_fill;
  logic [WERR_W-1:0]      w_win_errs_sum;

`ifdef PRBS31_CHK_INV_EN
  assign w_din = din ^ inv;
`else
  assign w_din = din;
`endif

  prbs31_lfsr_step u_step (
    .i_sr      (r_sr),
    .o_bit     (w_pred),
    .o_sr_next (w_sr_pred)
  );

  assign w_sr_fill      = {r_sr[PRBS_LEN-2:0], w_din};
  assign w_mismatch     = w_din ^ w_pred;
  assign w_win_errs_sum = r_win_errs + WERR_W'(w_mismatch);

  always_comb begin
    w_state_nxt    = r_state;
    w_sr_nxt       = r_sr;
    w_fill_nxt     = r_fill;
    w_match_nxt    = r_match;
    w_win_cnt_nxt  = r_win_cnt;
    w_win_errs_nxt = r_win_errs;
    w_err_hit      = 1'b0;
    if (din_vld) begin
      case (r_state)
        ST_SEARCH: begin
          w_sr_nxt = w_sr_fill;
          if (r_fill == FILL_W'(PRBS_LEN - 1)) begin
            // An all-zero register is the LFSR lock-up state; refill instead of verifying it
            w_fill_nxt = '0;
            if (w_sr_fill != '0) begin
              w_state_nxt = ST_VERIFY;
              w_match_nxt = '0;
            end
          end else begin
            w_fill_nxt = r_fill + FILL_W'(1);
          end
        end
        ST_VERIFY: begin
          w_sr_nxt = w_sr_pred;
          if (w_mismatch) begin
            w_state_nxt = ST_SEARCH;
            w_fill_nxt  = '0;
          end else if (r_match == MATCH_W'(LOCK_CNT - 1)) begin
            w_state_nxt    = ST_LOCKED;
            w_match_nxt    = '0;
            w_win_cnt_nxt  = '0;
            w_win_errs_nxt = '0;
          end else begin
            w_match_nxt = r_match + MATCH_W'(1);
          end
        end
        ST_LOCKED: begin
          // Register follows the prediction so one flipped channel bit is counted once
          w_sr_nxt  = w_sr_pred;
          w_err_hit = w_mismatch;
          if (w_win_errs_sum == WERR_W'(UNLOCK_ERRS)) begin
            w_state_nxt    = ST_SEARCH;
            w_fill_nxt     = '0;
            w_win_cnt_nxt  = '0;
            w_win_errs_nxt = '0;
          end else if (r_win_cnt == WIN_W'(WIN_LEN - 1)) begin
            w_win_cnt_nxt  = '0;
            w_win_errs_nxt = '0;
          end else begin
            w_win_cnt_nxt  = r_win_cnt + WIN_W'(1);
            w_win_errs_nxt = w_win_errs_sum;
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_fill_nxt  = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_err_cnt_nxt = r_err_cnt;
    if (clr_cnt) begin
      w_err_cnt_nxt = '0;
    end else if (w_err_hit && (r_err_cnt != '1)) begin
      w_err_cnt_nxt = r_err_cnt + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_SEARCH;
      r_sr        <= '0;
      r_fill      <= '0;
      r_match     <= '0;
      r_win_cnt   <= '0;
      r_win_errs  <= '0;
      r_locked    <= 1'b0;
      r_err_pulse <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_sr        <= w_sr_nxt;
      r_fill      <= w_fill_nxt;
      r_match     <= w_match_nxt;
      r_win_cnt   <= w_win_cnt_nxt;
      r_win_errs  <= w_win_errs_nxt;
      r_locked    <= (w_state_nxt == ST_LOCKED);
      r_err_pulse <= w_err_hit;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_prbs31_checker.sv
// tb/tb_prbs31_checker.sv - directed and randomized bench for prbs31_checker against a queue-based model
module tb_prbs31_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        din_vld = 1'b0;
  logic        din = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        locked;
  logic        err_pulse;
  logic [15:0] err_cnt;
`ifdef PRBS31_CHK_INV_EN
  logic        inv = 1'b0;
`endif

  prbs31_checker #(.LOCK_CNT(64), .UNLOCK_ERRS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din_vld   (din_vld),
    .din       (din),
`ifdef PRBS31_CHK_INV_EN
    .inv       (inv),
`endif
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Generator: b[n] = b[n-31] ^ b[n-28], history queue oldest first
  bit g_hist[$];
  // Model: mode 0/1/2 = search/verify/locked; m_hist holds the last up-to-31 reference bits
  int m_mode;
  bit m_hist[$];
  int m_match, m_win, m_werr, m_errcnt;
  bit m_pulse;

  int vb, lock_at, unlock_at, pulses, pulse_at, rises;
  bit prev_lk;

  task automatic gen_seed(input logic [30:0] s);
    g_hist.delete();
    for (int i = 0; i < 31; i++) g_hist.push_back(s[i]);
  endtask

  function automatic bit gen_next();
    bit b;
    b = g_hist[0] ^ g_hist[3];
    void'(g_hist.pop_front());
    g_hist.push_back(b);
    return b;
  endfunction

  function automatic void model_reset();
    m_mode = 0; m_hist.delete(); m_match = 0; m_win = 0; m_werr = 0; m_errcnt = 0; m_pulse = 0;
  endfunction

  function automatic void model_step(input bit v, input bit d, input bit clr);
    bit pred, err;
    int ones;
    err = 0;
    if (v) begin
      if (m_mode == 0) begin
        m_hist.push_back(d);
        if (m_hist.size() == 31) begin
          ones = 0;
          foreach (m_hist[i]) ones += int'(m_hist[i]);
          if (ones == 0) m_hist.delete();
          else begin m_mode = 1; m_match = 0; end
        end
      end else begin
        pred = m_hist[0] ^ m_hist[3];
        void'(m_hist.pop_front());
        m_hist.push_back(pred);
        if (m_mode == 1) begin
          if (pred != d) begin m_mode = 0; m_hist.delete(); end
          else begin
            m_match++;
            if (m_match == 64) begin m_mode = 2; m_win = 0; m_werr = 0; end
          end
        end else begin
          err = (pred != d);
          m_win++;
          if (err) m_werr++;
          if (m_werr == 8) begin m_mode = 0; m_hist.delete(); end
          else if (m_win == 256) begin m_win = 0; m_werr = 0; end
        end
      end
    end
    m_pulse = err;
    if (clr) m_errcnt = 0;
    else if (err && m_errcnt < 65535) m_errcnt++;
  endfunction

  task automatic check(input string tag);
    n_cmp++;
    assert (locked === (m_mode == 2)) else begin
      n_fail++; $error("FAIL %s locked observed=%0b expected=%0b", tag, locked, (m_mode == 2));
    end
    n_cmp++;
    assert (err_pulse === m_pulse) else begin
      n_fail++; $error("FAIL %s err_pulse observed=%0b expected=%0b", tag, err_pulse, m_pulse);
    end
    n_cmp++;
    assert (err_cnt === 16'(m_errcnt)) else begin
      n_fail++; $error("FAIL %s err_cnt observed=%0d expected=%0d", tag, err_cnt, m_errcnt);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++; $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input bit v, input bit d, input bit clr);
    din_vld = v; din = d; clr_cnt = clr;
    @(posedge clk);
    model_step(v, d, clr);
    @(negedge clk);
    check("cycle");
  endtask

  task automatic do_reset(input bit clr);
    rst = 1'b1; din_vld = 1'b1; din = 1'($urandom); clr_cnt = clr;
    @(posedge clk);
    model_reset();
    @(negedge clk);
    rst = 1'b0; prev_lk = 1'b0;
    check("reset");
  endtask

  task automatic begin_stream(input logic [30:0] seed);
    gen_seed(seed);
    vb = 0; lock_at = -1; unlock_at = -1; pulses = 0; pulse_at = -1; rises = 0;
  endtask

  task automatic send(input bit v, input bit flip, input bit clr);
    bit d;
    if (v) begin d = gen_next() ^ flip; vb++; end
    else d = 1'($urandom);
    tick(v, d, clr);
    if (err_pulse === 1'b1) begin pulses++; pulse_at = vb; end
    if (locked === 1'b1 && !prev_lk) begin lock_at = vb; rises++; end
    if (locked === 1'b0 && prev_lk) unlock_at = vb;
    prev_lk = (locked === 1'b1);
  endtask

  function automatic logic [30:0] rand_seed();
    return 31'($urandom) | 31'd1;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int p[8];
    bit ever, fl, v, cl;
    int nb;
    model_reset();
    @(negedge clk);

    // Seeded all-ones, contiguous input
    do_reset(1'b0);
    begin_stream(31'h7FFF_FFFF);
    for (int i = 1; i <= 200; i++) send(1'b1, 1'b0, 1'b0);
    chk_int("lock_bit_contig", lock_at, 31 + 64);
    chk_int("errcnt_clean", int'(err_cnt), 0);

    // Single flipped bit while locked
    do_reset(1'b0);
    begin_stream(rand_seed());
    for (int i = 1; i <= 300; i++) send(1'b1, (i == 150), 1'b0);
    chk_int("single_err_pulses", pulses, 1);
    chk_int("single_err_pulse_bit", pulse_at, 150);
    chk_int("single_err_cnt", int'(err_cnt), 1);
    chk_int("single_err_locked", int'(locked), 1);

    // Eight errors inside the first window force loss of lock, then relock
    do_reset(1'b0);
    begin_stream(rand_seed());
    for (int k = 0; k < 8; k++) p[k] = 100 + k * 30 + int'($urandom_range(0, 29));
    for (int i = 1; i <= 500; i++) begin
      fl = 1'b0;
      for (int k = 0; k < 8; k++) if (p[k] == i) fl = 1'b1;
      send(1'b1, fl, 1'b0);
    end
    chk_int("unlock_bit", unlock_at, p[7]);
    chk_int("unlock_err_cnt", int'(err_cnt), 8);
    chk_int("relock_bit", lock_at, p[7] + 95);
    chk_int("lock_rises", rises, 2);

    // All-zero input never locks
    do_reset(1'b0);
    ever = 1'b0;
    for (int i = 0; i < 500; i++) begin
      tick(1'b1, 1'b0, 1'b0);
      if (locked === 1'b1) ever = 1'b1;
    end
    chk_int("zeros_never_lock", int'(ever), 0);

    // Gapped valid input, then clear coincident with an error
    do_reset(1'b0);
    begin_stream(rand_seed());
    for (int i = 0; i < 440; i++) begin
      v = (i % 2 == 0);
      nb = vb + 1;
      fl = v && (nb == 150 || nb == 200);
      cl = v && (nb == 200);
      send(v, fl, cl);
    end
    chk_int("lock_bit_gapped", lock_at, 95);
    chk_int("gapped_pulses", pulses, 2);
    chk_int("clr_wins_err_cnt", int'(err_cnt), 0);

    // Reset mid-lock with five counted errors and coincident clear
    do_reset(1'b0);
    begin_stream(rand_seed());
    for (int i = 1; i <= 200; i++)
      send(1'b1, (i == 120 || i == 130 || i == 140 || i == 150 || i == 160), 1'b0);
    chk_int("pre_rst_err_cnt", int'(err_cnt), 5);
    chk_int("pre_rst_locked", int'(locked), 1);
    do_reset(1'b1);
    chk_int("post_rst_locked", int'(locked), 0);
    chk_int("post_rst_err_cnt", int'(err_cnt), 0);

    // Saturation: preload the counter, then inject further errors
    vb = 0; lock_at = -1;
    for (int i = 1; i <= 120; i++) send(1'b1, 1'b0, 1'b0);
    chk_int("relock_after_rst", lock_at, 95);
    force dut.r_err_cnt = 16'hFFFF;
    m_errcnt = 65535;
    send(1'b1, 1'b0, 1'b0);
    release dut.r_err_cnt;
    send(1'b1, 1'b1, 1'b0);
    send(1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b0);
    chk_int("saturated_err_cnt", int'(err_cnt), 65535);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
